spi_omega_bank: RTL and testbench

SPI_OMEGA_BANK -- requirements
Module: spi_omega_bank

---
 rtl/spi_omega_bank.sv | 153 +++++++++++++++
 tb/tb_spi_omega_bank.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_omega_bank.sv
`default_nettype none
// ============================================================================
// Module   : spi_omega_bank
// Brief    : SPI (mode 0) slave that loads per-channel tuning words into a
//            shadow bank and commits the whole bank to the active outputs
//            atomically when a frame carries the COMMIT flag.
// Revision : 1.0 - initial release
// ============================================================================
module spi_omega_bank #(
  parameter int OMEGA_W     = 40,
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sck,
  input  logic                   mosi,
  input  logic                   ssel,
  output logic [NCH*OMEGA_W-1:0] omega,
  output logic                   update,
  output logic                   frame_err
);

  localparam int            c_fw       = 8 + OMEGA_W;
  localparam int            c_cw       = $clog2(c_fw + 2);
  localparam logic [c_cw-1:0] c_cnt_full = c_cw'(c_fw);
  localparam logic [c_cw-1:0] c_cnt_sat  = c_cw'(c_fw + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Bit 0 is the newest sample; bit SYNC_STAGES is the history flop.
  logic [SYNC_STAGES:0] r_sck_s;
  logic [SYNC_STAGES:0] r_mosi_s;
  logic [SYNC_STAGES:0] r_ssel_s;

  state_t            r_state;
  state_t            w_next;
  logic [c_cw-1:0]   r_cnt;
  logic [c_fw-1:0]   r_shreg;
  logic [OMEGA_W-1:0] r_shadow [NCH];
  logic [OMEGA_W-1:0] r_active [NCH];

  logic              w_sck_rise;
  logic              w_ssel_rise;
  logic              w_ssel_fall;
  logic              w_ssel_low;
  logic              w_mosi_bit;
  logic              w_shift_en;
  logic              w_latch;
  logic              w_valid;
  logic              w_commit;
  logic [6:0]        w_chan;
  logic [OMEGA_W-1:0] w_data;

  // Synchronize the asynchronous SPI pins; reset to the bus idle levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sck_s  <= '0;
      r_mosi_s <= '0;
      r_ssel_s <= '1;
    end else begin
      r_sck_s  <= {r_sck_s[SYNC_STAGES-1:0], sck};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-1:0], mosi};
      r_ssel_s <= {r_ssel_s[SYNC_STAGES-1:0], ssel};
    end
  end

  assign w_sck_rise  = r_sck_s[SYNC_STAGES-1] & ~r_sck_s[SYNC_STAGES];
  assign w_ssel_rise = r_ssel_s[SYNC_STAGES-1] & ~r_ssel_s[SYNC_STAGES];
  assign w_ssel_fall = ~r_ssel_s[SYNC_STAGES-1] & r_ssel_s[SYNC_STAGES];
  assign w_ssel_low  = ~r_ssel_s[SYNC_STAGES-1];
  // mosi is stable for half an sck period around the rising edge, so the
  // history sample aligned with the detected edge is safe to capture.
  assign w_mosi_bit  = r_mosi_s[SYNC_STAGES];

  assign w_shift_en = (r_state == SHIFT) && w_ssel_low && w_sck_rise && !w_ssel_fall;
  assign w_latch    = (r_state == SHIFT) && w_ssel_rise;

  assign w_commit = r_shreg[c_fw-1];
  assign w_chan   = r_shreg[c_fw-2 -: 7];
  assign w_data   = r_shreg[OMEGA_W-1:0];
  assign w_valid  = (r_cnt == c_cnt_full) && (int'(w_chan) < NCH);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; a rise and fall seen together closes the old frame
  // and goes straight back to shifting a new one.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_ssel_fall) w_next = SHIFT;
      SHIFT:   if (w_ssel_rise) w_next = w_ssel_fall ? SHIFT : LATCH;
      LATCH:   w_next = w_ssel_fall ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bit counter and shift register; a new frame always starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_shreg <= '0;
    end else if (w_ssel_fall) begin
      r_cnt   <= '0;
      r_shreg <= '0;
    end else if (w_shift_en) begin
      r_shreg <= {r_shreg[c_fw-2:0], w_mosi_bit};
      if (r_cnt != c_cnt_sat) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Frame acceptance: shadow write, optional atomic commit, error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      update    <= 1'b0;
      frame_err <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
    end else begin
      update    <= 1'b0;
      frame_err <= 1'b0;
      if (w_latch) begin
        if (w_valid) begin
          for (int k = 0; k < NCH; k++) begin
            if (w_chan == 7'(k)) r_shadow[k] <= w_data;
            if (w_commit) r_active[k] <= (w_chan == 7'(k)) ? w_data : r_shadow[k];
          end
          update <= w_commit;
        end else if (r_cnt != '0) begin
          frame_err <= 1'b1;
        end
      end
    end
  end

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_ch
      assign omega[k*OMEGA_W +: OMEGA_W] = r_active[k];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_spi_omega_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_omega_bank
// Brief    : Scoreboard bench for spi_omega_bank: randomized SPI frames are
//            scored against a frame-level model of the shadow/active bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_omega_bank;

  localparam int OW = 40;
  localparam int N  = 4;
  localparam int FW = 8 + OW;

  typedef struct {
    bit              is_upd;
    logic [N*OW-1:0] om;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck = 1'b0;
  logic mosi = 1'b0;
  logic ssel = 1'b1;
  logic [N*OW-1:0] omega;
  logic update;
  logic frame_err;

  int checks = 0;
  int errors = 0;

  exp_t            exp_q[$];
  logic [OW-1:0]   sh_m [N];
  logic [OW-1:0]   ac_m [N];
  logic [N*OW-1:0] mon_om = '0;

  always #5 clk = ~clk;

  spi_omega_bank #(.OMEGA_W(OW), .NCH(N), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .ssel(ssel),
    .omega(omega), .update(update), .frame_err(frame_err)
  );

  function automatic logic [N*OW-1:0] pack_m();
    logic [N*OW-1:0] r;
    for (int k = 0; k < N; k++) r[k*OW +: OW] = ac_m[k];
    return r;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < N; k++) begin
      sh_m[k] = '0;
      ac_m[k] = '0;
    end
  endtask

  // Frame-level rules: only an exact-length frame to an existing channel is
  // accepted; COMMIT publishes the whole shadow bank at once.
  task automatic model_frame(input logic [127:0] bits, input int nbits);
    exp_t e;
    logic [7:0]    hdr;
    logic [OW-1:0] data;
    hdr  = bits[FW-1 -: 8];
    data = bits[OW-1:0];
    if (nbits == 0) return;
    if (nbits == FW && int'(hdr[6:0]) < N) begin
      sh_m[hdr[6:0]] = data;
      if (hdr[7]) begin
        for (int k = 0; k < N; k++) ac_m[k] = sh_m[k];
        e.is_upd = 1'b1;
        e.om     = pack_m();
        exp_q.push_back(e);
      end
    end else begin
      e.is_upd = 1'b0;
      e.om     = pack_m();
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [127:0] bits, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = bits[i];
      wait_clk(8);
      sck = 1'b1;
      wait_clk(8);
      sck = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d expected responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    wait_clk(4);
  endtask

  task automatic frame(input logic [127:0] bits, input int nbits);
    ssel = 1'b0;
    wait_clk(32);
    send_bits(bits, nbits);
    wait_clk(32);
    model_frame(bits, nbits);
    ssel = 1'b1;
    wait_clk(32);
    drain();
  endtask

  task automatic check_omega(input string name, input logic [N*OW-1:0] req);
    checks++;
    if (omega !== req) begin
      errors++;
      $display("FAIL %s: omega=%h required %h", name, omega, req);
    end
  endtask

  // Monitor: every pulse must match the next expected response; between
  // pulses the active words must not move.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      mon_om = '0;
    end else if (update || frame_err) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious: update=%b frame_err=%b with nothing expected", update, frame_err);
      end else begin
        e = exp_q.pop_front();
        if (update !== e.is_upd || frame_err !== !e.is_upd || omega !== e.om) begin
          errors++;
          $display("FAIL response: update=%b frame_err=%b omega=%h required update=%b frame_err=%b omega=%h",
                   update, frame_err, omega, e.is_upd, !e.is_upd, e.om);
        end
        mon_om = e.om;
      end
    end else begin
      checks++;
      if (omega !== mon_om) begin
        errors++;
        $display("FAIL stable: omega=%h required %h", omega, mon_om);
      end
    end
  end

  initial begin
    logic [127:0] bits;
    logic [63:0]  d;
    logic [7:0]   hdr;
    int           sel;
    int           nb;

    clear_model();
    wait_clk(6);
    checks++;
    if (omega !== '0 || update !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: omega=%h update=%b frame_err=%b required 0 0 0", omega, update, frame_err);
    end
    rst = 1'b0;
    wait_clk(10);

    frame({80'h0, 8'h82, 40'h12_3456_789A}, FW);
    check_omega("ch2_commit", {40'h0, 40'h12_3456_789A, 80'h0});

    frame({80'h0, 8'h01, 40'hAA_AAAA_AAAA}, FW);
    check_omega("shadow_only", {40'h0, 40'h12_3456_789A, 80'h0});
    frame({80'h0, 8'h80, 40'h55_5555_5555}, FW);
    check_omega("commit_all", {40'h0, 40'h12_3456_789A, 40'hAA_AAAA_AAAA, 40'h55_5555_5555});

    frame({$urandom(), $urandom(), $urandom(), $urandom()}, FW - 1);
    frame({$urandom(), $urandom(), $urandom(), $urandom()}, FW + 1);
    frame({$urandom(), $urandom(), $urandom(), $urandom()}, FW + 20);
    frame({80'h0, 8'h85, 40'hDE_ADBE_EF01}, FW);
    frame({80'h0, 8'hFF, 40'h01_0203_0405}, FW);
    frame({80'h0, 8'h80, 40'h00_0000_0000}, FW);
    check_omega("after_errors", {40'h0, 40'h12_3456_789A, 40'hAA_AAAA_AAAA, 40'h0});

    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      d   = {$urandom(), $urandom()};
      hdr = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 5))};
      if (i % 10 == 9) hdr[6:0] = 7'h7F;
      case (sel)
        0:       nb = FW - 1;
        1:       nb = FW + 1;
        2:       nb = 0;
        3:       nb = FW + 8;
        default: nb = FW;
      endcase
      if (nb == FW) bits = {80'h0, hdr, d[OW-1:0]};
      else          bits = {$urandom(), $urandom(), $urandom(), $urandom()};
      frame(bits, nb);
    end
    check_omega("random_end", pack_m());

    // Abort a frame with reset part-way through its bits.
    ssel = 1'b0;
    wait_clk(32);
    send_bits({$urandom(), $urandom(), $urandom(), $urandom()}, 20);
    rst  = 1'b1;
    ssel = 1'b1;
    sck  = 1'b0;
    wait_clk(10);
    clear_model();
    rst = 1'b0;
    wait_clk(10);
    check_omega("post_reset", '0);

    frame({80'h0, 8'h80, 40'h00_0000_0001}, FW);
    check_omega("post_reset_frame", {{(N*OW-1){1'b0}}, 1'b1});

    frame('0, 0);
    frame('0, 0);
    check_omega("ssel_toggle", {{(N*OW-1){1'b0}}, 1'b1});

    wait_clk(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
